// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential BCD-to-binary converter (reverse double-dabble, one bit per clock)
module bcd_to_binary_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // The widest decimal value must fit in the binary result.
    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
        $fatal(1, "bcd_to_binary_seq: DIGITS must be in 1..4");
    end
    if ((longint'(1) << BIN_W) < pow10(DIGITS)) begin : g_bad_width
        $fatal(1, "bcd_to_binary_seq: BIN_W too small for DIGITS");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [BCD_W-1:0]   bcd_q;
    logic [BIN_W-1:0]   bin_q;
    logic [CNT_W-1:0]   cnt_q;
    // Set when the accepted word had a non-decimal digit: CONVERT then
    // lasts exactly one cycle and DONE is entered with err=1, so the error
    // result appears one edge after acceptance and err/bin_out still only
    // change on the DONE entry edge.
    logic               bad_q;

    logic               input_bad;
    logic [BCD_W-1:0]   shift_bcd;
    logic [BIN_W-1:0]   shift_bin;
    logic [BCD_W-1:0]   corr_bcd;
    logic               last_step;

    // Flag any input digit outside 0..9.
    always_comb begin
        input_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] > 4'd9) begin
                input_bad = 1'b1;
            end
        end
    end

    // One right shift of the concatenated {bcd, bin} pair.
    assign shift_bcd = bcd_q >> 1;
    assign shift_bin = {bcd_q[0], bin_q[BIN_W-1:1]};

    // Undo the halving error on every digit that came out as 8 or more.
    always_comb begin
        corr_bcd = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (shift_bcd[4*d +: 4] >= 4'd8) begin
                corr_bcd[4*d +: 4] = shift_bcd[4*d +: 4] - 4'd3;
            end else begin
                corr_bcd[4*d +: 4] = shift_bcd[4*d +: 4];
            end
        end
    end

    assign last_step = bad_q || (cnt_q == LAST_STEP);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    next_state = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (last_step) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath: capture, shift/correct per step, publish result on DONE entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        bin_q <= '0;
                        cnt_q <= '0;
                        if (input_bad) begin
                            bad_q <= 1'b1;
                            bcd_q <= '0;
                        end else begin
                            bad_q <= 1'b0;
                            bcd_q <= bcd_in;
                        end
                    end
                end
                S_CONVERT: begin
                    if (bad_q) begin
                        bad_q   <= 1'b0;
                        bin_out <= '0;
                        err     <= 1'b1;
                    end else begin
                        bcd_q <= corr_bcd;
                        bin_q <= shift_bin;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_STEP) begin
                            bin_out <= shift_bin;
                            err     <= 1'b0;
                        end
                    end
                end
                default: begin
                    bcd_q <= bcd_q;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Every BCD bit must have been shifted into the binary side by the last step.
    always @(posedge clk) begin
        if (reset_n && state == S_CONVERT && !bad_q && cnt_q == LAST_STEP) begin
            assert (corr_bcd == '0);
        end
    end
`endif

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb/tb_bcd_to_binary_seq.sv - self-checking bench for bcd_to_binary_seq
module tb_bcd_to_binary_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default 2 digits / 7 bits
    logic        rst_a = 1'b0;
    logic        valid_a = 1'b0;
    logic        ready_a;
    logic [7:0]  bcd_a = 8'h00;
    logic        ovalid_a;
    logic        ordy_a = 1'b1;
    logic [6:0]  bin_a;
    logic        err_a;

    // Instance B: 3 digits / 10 bits
    logic        rst_b = 1'b0;
    logic        valid_b = 1'b0;
    logic        ready_b;
    logic [11:0] bcd_b = 12'h000;
    logic        ovalid_b;
    logic        ordy_b = 1'b1;
    logic [9:0]  bin_b;
    logic        err_b;

    bcd_to_binary_seq #(.DIGITS(2), .BIN_W(7)) dut_a (
        .clk(clk), .reset_n(rst_a),
        .in_valid(valid_a), .in_ready(ready_a), .bcd_in(bcd_a),
        .out_valid(ovalid_a), .out_ready(ordy_a),
        .bin_out(bin_a), .err(err_a)
    );

    bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut_b (
        .clk(clk), .reset_n(rst_b),
        .in_valid(valid_b), .in_ready(ready_b), .bcd_in(bcd_b),
        .out_valid(ovalid_b), .out_ready(ordy_b),
        .bin_out(bin_b), .err(err_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Timeline view: a job accepted at edge number acc becomes visible after
    // edge acc+lat (lat = BIN_W for decimal input, 1 for a bad digit) and is
    // shown until consumed by an out_ready edge; bin_out/err keep the last
    // published value; input is taken only when no job is outstanding.
    int          m_cyc  [2];
    int          m_acc  [2];
    int          m_lat  [2];
    bit          m_busy [2];
    int          m_val  [2];
    bit          m_err  [2];
    int          m_show [2];
    bit          m_serr [2];

    function automatic bit dec_bad(input logic [15:0] b, input int nd);
        bit r = 0;
        for (int i = 0; i < nd; i++) begin
            if (b[4*i +: 4] > 4'd9) r = 1;
        end
        return r;
    endfunction

    function automatic int dec_val(input logic [15:0] b, input int nd);
        int v = 0;
        int w = 1;
        for (int i = 0; i < nd; i++) begin
            v += int'(b[4*i +: 4]) * w;
            w *= 10;
        end
        return v;
    endfunction

    function automatic bit exp_ov(input int u);
        return m_busy[u] && (m_cyc[u] >= m_acc[u] + m_lat[u]);
    endfunction

    task automatic model_reset(input int u);
        m_busy[u] = 0;
        m_show[u] = 0;
        m_serr[u] = 0;
        m_val[u]  = 0;
        m_err[u]  = 0;
    endtask

    task automatic model_edge(input int u, input logic v, input logic [15:0] b,
                              input logic ordy, input int nd, input int bw);
        bit ov;
        ov = exp_ov(u);
        m_cyc[u]++;
        if (ov && ordy) begin
            m_busy[u] = 0;
        end else if (!m_busy[u] && v) begin
            m_busy[u] = 1;
            m_acc[u]  = m_cyc[u];
            if (dec_bad(b, nd)) begin
                m_err[u] = 1;
                m_val[u] = 0;
                m_lat[u] = 1;
            end else begin
                m_err[u] = 0;
                m_val[u] = dec_val(b, nd);
                m_lat[u] = bw;
            end
        end
        if (m_busy[u] && m_cyc[u] == m_acc[u] + m_lat[u]) begin
            m_show[u] = m_val[u];
            m_serr[u] = m_err[u];
        end
    endtask

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) model_reset(0);
        else        model_edge(0, valid_a, {8'h00, bcd_a}, ordy_a, 2, 7);
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) model_reset(1);
        else        model_edge(1, valid_b, {4'h0, bcd_b}, ordy_b, 3, 10);
    end

    // ---------------- per-cycle compare ----------------
    int hs_b = 0;

    always @(negedge clk) begin
        check("a_in_ready",  32'(ready_a),  32'(!m_busy[0]));
        check("a_out_valid", 32'(ovalid_a), 32'(exp_ov(0)));
        check("a_bin_out",   32'(bin_a),    32'(m_show[0]));
        check("a_err",       32'(err_a),    32'(m_serr[0]));
        check("b_in_ready",  32'(ready_b),  32'(!m_busy[1]));
        check("b_out_valid", 32'(ovalid_b), 32'(exp_ov(1)));
        check("b_bin_out",   32'(bin_b),    32'(m_show[1]));
        check("b_err",       32'(err_b),    32'(m_serr[1]));
        if (ovalid_b === 1'b1 && ordy_b) hs_b++;
    end

    bit rnd_en = 0;
    always @(posedge clk) begin
        #2;
        if (rnd_en) ordy_b = 1'($urandom_range(0, 1));
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_ready_a(input string name);
        int w = 0;
        while (!ready_a && w < 50) begin
            @(negedge clk);
            w++;
        end
        check(name, 32'(w >= 50), 32'd0);
    endtask

    task automatic convert_a(input logic [7:0] v, output int lat,
                             output logic [6:0] b, output logic e);
        bcd_a   = v;
        valid_a = 1'b1;
        wait_ready_a("a_accept_timeout");
        @(negedge clk);
        valid_a = 1'b0;
        bcd_a   = 8'hEE;
        lat = 0;
        while (!ovalid_a && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        b = bin_a;
        e = err_a;
    endtask

    typedef struct {
        logic [7:0] bcd;
        int         val;
        bit         e;
        int         lat;
    } vec_t;

    vec_t vecs[7] = '{
        '{8'h42, 42, 0, 7},
        '{8'h00,  0, 0, 7},
        '{8'h99, 99, 0, 7},
        '{8'h09,  9, 0, 7},
        '{8'h10, 10, 0, 7},
        '{8'h3A,  0, 1, 1},
        '{8'hF0,  0, 1, 1}
    };

    initial begin
        int         lat;
        logic [6:0] b;
        logic       e;
        int         w;

        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  32'(ready_a),  32'd1);
        check("rst_out_valid", 32'(ovalid_a), 32'd0);
        check("rst_bin_out",   32'(bin_a),    32'd0);
        check("rst_err",       32'(err_a),    32'd0);

        // directed conversions, out_ready held high
        foreach (vecs[i]) begin
            convert_a(vecs[i].bcd, lat, b, e);
            check($sformatf("lat_%02h", vecs[i].bcd), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("bin_%02h", vecs[i].bcd), 32'(b),   32'(vecs[i].val));
            check($sformatf("err_%02h", vecs[i].bcd), 32'(e),   32'(vecs[i].e));
        end
        @(negedge clk);
        check("ready_after_handshake", 32'(ready_a), 32'd1);

        // backpressure with ignored input pulses
        ordy_a  = 1'b0;
        bcd_a   = 8'h25;
        valid_a = 1'b1;
        wait_ready_a("bp_accept_timeout");
        @(negedge clk);
        bcd_a = 8'h77;
        repeat (3) @(negedge clk);
        valid_a = 1'b0;
        w = 0;
        while (!ovalid_a && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("bp_valid_timeout", 32'(w >= 50), 32'd0);
        bcd_a   = 8'h88;
        valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(ovalid_a), 32'd1);
            check("bp_hold_bin",   32'(bin_a),    32'd25);
        end
        valid_a = 1'b0;
        ordy_a  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_valid", 32'(ovalid_a), 32'd0);
        check("bp_release_ready", 32'(ready_a),  32'd1);
        check("bp_release_bin",   32'(bin_a),    32'd25);

        // reset during CONVERT
        bcd_a   = 8'h57;
        valid_a = 1'b1;
        wait_ready_a("rst_accept_timeout");
        @(negedge clk);
        valid_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst_a = 1'b0;
        #1;
        check("midrst_in_ready",  32'(ready_a),  32'd1);
        check("midrst_out_valid", 32'(ovalid_a), 32'd0);
        check("midrst_bin_out",   32'(bin_a),    32'd0);
        check("midrst_err",       32'(err_a),    32'd0);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        convert_a(8'h12, lat, b, e);
        check("post_rst_lat", 32'(lat), 32'd7);
        check("post_rst_bin", 32'(b),   32'd12);
        check("post_rst_err", 32'(e),   32'd0);

        // exhaustive 3-digit sweep with random out_ready
        rnd_en  = 1;
        valid_b = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            bcd_b = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            w = 0;
            while (!ready_b && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) check("b_accept_timeout", 32'(w), 32'd0);
            @(negedge clk);
            valid_b = (i != 999);
        end
        valid_b = 1'b0;
        w = 0;
        while (!ready_b && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("b_drain_timeout", 32'(w >= 200), 32'd0);
        rnd_en = 0;
        ordy_b = 1'b1;
        check("b_result_count", 32'(hs_b), 32'd1000);
        check("b_last_bin", 32'(bin_b), 32'd999);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
